// File: rtl/rsa_ctrl_pkg.sv
// Shared state encoding and sizing constants for the RSA stream controller.
package rsa_ctrl_pkg;
    localparam int RSA_BITS      = 256;
    localparam int RSA_IN_BYTES  = 32;
    localparam int RSA_OUT_BYTES = 31;

    typedef enum logic [2:0] {
        S_GET_N,
        S_GET_D,
        S_GET_A,
        S_START,
        S_WAIT,
        S_SEND
    } rsa_ctrl_state_e;
endpackage

// File: rtl/rsa_byte_shifter.sv
// Wide register with parallel load, clear and an MSB-first byte shift
// (shift-in when byte_in carries data, shift-out when byte_in is zero).
module rsa_byte_shifter
    import rsa_ctrl_pkg::*;
#(
    parameter int BITS = RSA_BITS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            load,
    input  logic [BITS-1:0] load_value,
    input  logic            shift,
    input  logic [7:0]      byte_in,
    output logic [BITS-1:0] value
);
    logic [BITS-1:0] value_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_reg <= '0;
        end else if (clr) begin
            value_reg <= '0;
        end else if (load) begin
            value_reg <= load_value;
        end else if (shift) begin
            value_reg <= {value_reg[BITS-9:0], byte_in};
        end
    end

    assign value = value_reg;
endmodule

// File: rtl/rsa_stream_ctrl.sv
// Sequences one RSA decryption core: gathers N, d and ciphertext blocks from a
// byte stream, starts the core, and streams back the plaintext bytes.
module rsa_stream_ctrl
    import rsa_ctrl_pkg::*;
#(
    parameter int BITS      = RSA_BITS,
    parameter int IN_BYTES  = BITS / 8,
    parameter int OUT_BYTES = RSA_OUT_BYTES
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_rx_valid,
    input  logic [7:0]      i_rx_data,
    output logic            o_rx_ready,
    output logic            o_tx_valid,
    output logic [7:0]      o_tx_data,
    input  logic            i_tx_ready,
    input  logic            i_key_reload,
    output logic            o_core_start,
    output logic [BITS-1:0] o_core_n,
    output logic [BITS-1:0] o_core_d,
    output logic [BITS-1:0] o_core_a,
    input  logic [BITS-1:0] i_core_result,
    input  logic            i_core_finished,
    output logic            o_busy
);
    localparam int CW = $clog2(IN_BYTES);
    localparam logic [CW-1:0] RX_LAST = CW'(IN_BYTES - 1);
    localparam logic [CW-1:0] TX_LAST = CW'(OUT_BYTES - 1);

    rsa_ctrl_state_e state_reg;
    logic [CW-1:0]   rx_cnt_reg;
    logic [CW-1:0]   tx_cnt_reg;
    logic [BITS-1:0] n_reg, d_reg, a_reg;
    logic [BITS-1:0] rx_value, tx_value, rx_word;
    logic            in_get, reload_hit, rx_fire, rx_last, tx_fire, res_load;

    assign in_get     = state_reg inside {S_GET_N, S_GET_D, S_GET_A};
    assign reload_hit = (state_reg == S_GET_A) && i_key_reload;
    // A reload in the same cycle as a byte wins; the byte is simply not taken.
    assign rx_fire    = in_get && i_rx_valid && !reload_hit;
    assign rx_last    = (rx_cnt_reg == RX_LAST);
    assign rx_word    = {rx_value[BITS-9:0], i_rx_data};
    assign tx_fire    = (state_reg == S_SEND) && i_tx_ready;
    assign res_load   = (state_reg == S_WAIT) && i_core_finished;

    rsa_byte_shifter #(.BITS(BITS)) u_rx_shifter (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .clr        (reload_hit || (rx_fire && rx_last)),
        .load       (1'b0),
        .load_value ('0),
        .shift      (rx_fire && !rx_last),
        .byte_in    (i_rx_data),
        .value      (rx_value)
    );

    rsa_byte_shifter #(.BITS(BITS)) u_tx_shifter (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .clr        (1'b0),
        .load       (res_load),
        .load_value (i_core_result),
        .shift      (tx_fire),
        .byte_in    (8'h00),
        .value      (tx_value)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg  <= S_GET_N;
            rx_cnt_reg <= '0;
            tx_cnt_reg <= '0;
            n_reg      <= '0;
            d_reg      <= '0;
            a_reg      <= '0;
        end else begin
            case (state_reg)
                S_GET_N, S_GET_D, S_GET_A: begin
                    if (reload_hit) begin
                        rx_cnt_reg <= '0;
                        state_reg  <= S_GET_N;
                    end else if (rx_fire) begin
                        if (rx_last) begin
                            rx_cnt_reg <= '0;
                            if (state_reg == S_GET_N) begin
                                n_reg     <= rx_word;
                                state_reg <= S_GET_D;
                            end else if (state_reg == S_GET_D) begin
                                d_reg     <= rx_word;
                                state_reg <= S_GET_A;
                            end else begin
                                a_reg     <= rx_word;
                                state_reg <= S_START;
                            end
                        end else begin
                            rx_cnt_reg <= rx_cnt_reg + 1'b1;
                        end
                    end
                end
                S_START: state_reg <= S_WAIT;
                S_WAIT: begin
                    if (i_core_finished) begin
                        state_reg <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (i_tx_ready) begin
                        if (tx_cnt_reg == TX_LAST) begin
                            tx_cnt_reg <= '0;
                            state_reg  <= S_GET_A;
                        end else begin
                            tx_cnt_reg <= tx_cnt_reg + 1'b1;
                        end
                    end
                end
                default: state_reg <= S_GET_N;
            endcase
        end
    end

    // Top result byte is discarded; transmission starts at bits [BITS-9 -: 8].
    assign o_rx_ready   = in_get;
    assign o_core_start = (state_reg == S_START);
    assign o_busy       = state_reg inside {S_START, S_WAIT, S_SEND};
    assign o_tx_valid   = (state_reg == S_SEND);
    assign o_tx_data    = o_tx_valid ? tx_value[BITS-9 -: 8] : 8'h00;
    assign o_core_n     = n_reg;
    assign o_core_d     = d_reg;
    assign o_core_a     = a_reg;

    logic unused_bits;
    assign unused_bits = ^{rx_value[BITS-1:BITS-8], tx_value[BITS-1:BITS-8],
                           tx_value[BITS-17:0]};
endmodule
